// File: rtl/vga_window_scaler_if.sv
// VRAM read port of vga_window_scaler: registered address/enable out, pixel data back.
interface vga_window_scaler_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] O_VRAM_ADDR;
  logic              O_VRAM_EN;
  logic [2:0]        I_VRAM_DATA;  // bit0=R, bit1=B, bit2=G

  modport master (output O_VRAM_ADDR, O_VRAM_EN, input I_VRAM_DATA);
  modport slave  (input O_VRAM_ADDR, O_VRAM_EN, output I_VRAM_DATA);
endinterface

// File: rtl/vga_window_scaler.sv
// VGA timing generator with a movable, integer-scaled framebuffer window.
// Sync, RGB and flags all leave the block RAM_LAT+2 cycles after the counter value.
module vga_window_scaler #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 24,
  parameter int H_SYNC      = 40,
  parameter int H_BP        = 128,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 9,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 29,
  parameter bit SYNC_POL    = 1'b0,
  parameter int WIN_W       = 256,
  parameter int WIN_H       = 256,
  parameter int SCALE_SHIFT = 0,
  parameter int ADDR_W      = 16,
  parameter int RAM_LAT     = 1
) (
  input  logic                 CLK,
  input  logic                 I_RESET,
  input  logic [9:0]           I_WIN_X,
  input  logic [9:0]           I_WIN_Y,
  input  logic [11:0]          I_BORDER,
  vga_window_scaler_if.master  vram,
  output logic                 O_HSYNC,
  output logic                 O_VSYNC,
  output logic [3:0]           O_VIDEO_R,
  output logic [3:0]           O_VIDEO_G,
  output logic [3:0]           O_VIDEO_B,
  output logic                 O_FRAME_START,
  output logic                 O_VBLANK
);

  localparam int          H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int          V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int          PIPE_N  = RAM_LAT + 1;
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] WIN_SW  = 12'(WIN_W << SCALE_SHIFT);
  localparam logic [11:0] WIN_SH  = 12'(WIN_H << SCALE_SHIFT);

  typedef struct packed {
    logic active;
    logic in_win;
    logic hs;
    logic vs;
    logic frame0;
    logic vblank;
  } flags_t;

  logic [10:0]       px_q, px_d, ln_q, ln_d;
  logic [9:0]        wx_q, wx_d, wy_q, wy_d;
  logic [11:0]       border_q, border_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_q, en_d;
  flags_t            pipe_q [PIPE_N];
  flags_t            pipe_d [PIPE_N];
  logic [11:0]       rgb_q, rgb_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;
  logic              fs_q, fs_d, vblank_q, vblank_d;

  logic              frame_end;
  logic [10:0]       dx, dy;
  flags_t            cur, out;

  // NOTE: always_comb assigns every output unconditionally first so no latch is inferred.
  always_comb begin
    frame_end = (px_q == H_LAST) && (ln_q == V_LAST);
    px_d      = (px_q == H_LAST) ? '0 : px_q + 11'd1;
    ln_d      = ln_q;
    if (px_q == H_LAST) ln_d = (ln_q == V_LAST) ? '0 : ln_q + 11'd1;

    // Window position and border only move on a frame boundary.
    wx_d     = frame_end ? I_WIN_X  : wx_q;
    wy_d     = frame_end ? I_WIN_Y  : wy_q;
    border_d = frame_end ? I_BORDER : border_q;

    // 11-bit two's-complement offsets; bit 10 set means left of / above the window.
    dx = px_q - {1'b0, wx_q};
    dy = ln_q - {1'b0, wy_q};

    cur.active = (px_q < H_ACT) && (ln_q < V_ACT);
    cur.in_win = cur.active && !dx[10] && ({1'b0, dx} < WIN_SW)
                            && !dy[10] && ({1'b0, dy} < WIN_SH);
    cur.hs     = (px_q >= HS_BEG) && (px_q < HS_END);
    cur.vs     = (ln_q >= VS_BEG) && (ln_q < VS_END);
    cur.frame0 = (px_q == '0) && (ln_q == '0);
    cur.vblank = (ln_q >= V_ACT);

    addr_d = '0;
    if (cur.in_win)
      addr_d = ADDR_W'((32'(dy[9:0]) >> SCALE_SHIFT) * 32'(WIN_W)
                       + (32'(dx[9:0]) >> SCALE_SHIFT));
    en_d = cur.in_win;

    pipe_d[0] = cur;
    for (int i = 1; i < PIPE_N; i++) pipe_d[i] = pipe_q[i-1];

    // Last flag stage lines up with the VRAM data of the same pixel.
    out   = pipe_q[PIPE_N-1];
    rgb_d = '0;
    if (out.in_win)
      rgb_d = {{4{vram.I_VRAM_DATA[0]}}, {4{vram.I_VRAM_DATA[2]}}, {4{vram.I_VRAM_DATA[1]}}};
    else if (out.active)
      rgb_d = border_q;
    hsync_d  = out.hs ? SYNC_POL : !SYNC_POL;
    vsync_d  = out.vs ? SYNC_POL : !SYNC_POL;
    fs_d     = out.frame0;
    vblank_d = out.vblank;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (I_RESET) begin
      px_q     <= '0;
      ln_q     <= '0;
      wx_q     <= I_WIN_X;
      wy_q     <= I_WIN_Y;
      border_q <= I_BORDER;
      addr_q   <= '0;
      en_q     <= 1'b0;
      // NOTE: the flag shift register is reset on purpose: stale flags would leak into output after reset.
      pipe_q   <= '{default: '0};
      rgb_q    <= '0;
      hsync_q  <= !SYNC_POL;
      vsync_q  <= !SYNC_POL;
      fs_q     <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      px_q     <= px_d;
      ln_q     <= ln_d;
      wx_q     <= wx_d;
      wy_q     <= wy_d;
      border_q <= border_d;
      addr_q   <= addr_d;
      en_q     <= en_d;
      pipe_q   <= pipe_d;
      rgb_q    <= rgb_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fs_q     <= fs_d;
      vblank_q <= vblank_d;
    end
  end

  assign vram.O_VRAM_ADDR = addr_q;
  assign vram.O_VRAM_EN   = en_q;
  assign O_HSYNC          = hsync_q;
  assign O_VSYNC          = vsync_q;
  assign O_VIDEO_R        = rgb_q[11:8];
  assign O_VIDEO_G        = rgb_q[7:4];
  assign O_VIDEO_B        = rgb_q[3:0];
  assign O_FRAME_START    = fs_q;
  assign O_VBLANK         = vblank_q;

endmodule

// File: tb/tb_vga_window_scaler.sv
// Directed bench: full-size default build (A), small-mode scaled RAM_LAT=3 build (B),
// small-mode RAM_LAT=1 build (C). Checks are placed at edge counts since reset release.
module tb_vga_window_scaler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n      = 0;
  int checks = 0;
  int errors = 0;

  logic [9:0]  win_x_a = 10'd192, win_y_a = 10'd4;
  logic [9:0]  win_x_b = 10'd0,   win_y_b = 10'd0;
  logic [9:0]  win_x_c = 10'd56,  win_y_c = 10'd40;
  logic [11:0] bord_a  = 12'hA5C, bord_b  = 12'h3C7, bord_c = 12'h123;

  localparam logic [11:0] BORD_C_NEW = 12'h9E1;

  logic       hs_a, vs_a, fs_a, vb_a, hs_b, vs_b, fs_b, vb_b, hs_c, vs_c, fs_c, vb_c;
  logic [3:0] r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;

  vga_window_scaler_if #(.ADDR_W(16)) vram_a ();
  vga_window_scaler_if #(.ADDR_W(8))  vram_b ();
  vga_window_scaler_if #(.ADDR_W(8))  vram_c ();

  // Behavioural VRAMs returning addr[2:0] with the latency each build expects.
  logic [2:0] ram_a_q = '0;
  logic [2:0] ram_c_q = '0;
  logic [2:0] ram_b_q [3] = '{3'd0, 3'd0, 3'd0};
  always @(posedge clk) begin
    ram_a_q    <= vram_a.O_VRAM_ADDR[2:0];
    ram_c_q    <= vram_c.O_VRAM_ADDR[2:0];
    ram_b_q[0] <= vram_b.O_VRAM_ADDR[2:0];
    ram_b_q[1] <= ram_b_q[0];
    ram_b_q[2] <= ram_b_q[1];
  end
  assign vram_a.I_VRAM_DATA = ram_a_q;
  assign vram_b.I_VRAM_DATA = ram_b_q[2];
  assign vram_c.I_VRAM_DATA = ram_c_q;

  vga_window_scaler dut_a (
    .CLK(clk), .I_RESET(rst), .I_WIN_X(win_x_a), .I_WIN_Y(win_y_a), .I_BORDER(bord_a),
    .vram(vram_a), .O_HSYNC(hs_a), .O_VSYNC(vs_a), .O_VIDEO_R(r_a), .O_VIDEO_G(g_a),
    .O_VIDEO_B(b_a), .O_FRAME_START(fs_a), .O_VBLANK(vb_a)
  );

  vga_window_scaler #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .WIN_W(16), .WIN_H(16), .SCALE_SHIFT(1), .ADDR_W(8), .RAM_LAT(3)
  ) dut_b (
    .CLK(clk), .I_RESET(rst), .I_WIN_X(win_x_b), .I_WIN_Y(win_y_b), .I_BORDER(bord_b),
    .vram(vram_b), .O_HSYNC(hs_b), .O_VSYNC(vs_b), .O_VIDEO_R(r_b), .O_VIDEO_G(g_b),
    .O_VIDEO_B(b_b), .O_FRAME_START(fs_b), .O_VBLANK(vb_b)
  );

  vga_window_scaler #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(4),
    .WIN_W(16), .WIN_H(16), .SCALE_SHIFT(0), .ADDR_W(8), .RAM_LAT(1)
  ) dut_c (
    .CLK(clk), .I_RESET(rst), .I_WIN_X(win_x_c), .I_WIN_Y(win_y_c), .I_BORDER(bord_c),
    .vram(vram_c), .O_HSYNC(hs_c), .O_VSYNC(vs_c), .O_VIDEO_R(r_c), .O_VIDEO_G(g_c),
    .O_VIDEO_B(b_c), .O_FRAME_START(fs_c), .O_VBLANK(vb_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    n++;
  endtask

  task automatic goto(input int target);
    while (n < target) step();
  endtask

  int cnt_hs, cnt_vs, cnt_vb, cnt_fs, cnt_en;

  initial begin
    // ---- power-on reset ----
    repeat (2) step();
    check("a_rst_rgb",  {r_a, g_a, b_a}, 12'h000);
    check("a_rst_hs",   hs_a, 1'b1);
    check("a_rst_vs",   vs_a, 1'b1);
    check("a_rst_en",   vram_a.O_VRAM_EN, 1'b0);
    check("a_rst_addr", vram_a.O_VRAM_ADDR, 16'h0);
    check("a_rst_fs",   fs_a, 1'b0);
    check("a_rst_vb",   vb_a, 1'b0);
    repeat (3) step();
    rst = 1'b0;
    n   = 0;

    // ---- line 0: first pixels, frame start latency, scaled addressing ----
    goto(1);  check("b_addr_p0", vram_b.O_VRAM_ADDR, 8'd0);
              check("b_en_p0",   vram_b.O_VRAM_EN, 1'b1);
              check("c_en_p0",   vram_c.O_VRAM_EN, 1'b0);
    goto(2);  check("a_fs_n2", fs_a, 1'b0);
              check("c_fs_n2", fs_c, 1'b0);
              check("b_addr_p1", vram_b.O_VRAM_ADDR, 8'd0);
    goto(3);  check("a_fs_n3", fs_a, 1'b1);
              check("c_fs_n3", fs_c, 1'b1);
              check("b_addr_p2", vram_b.O_VRAM_ADDR, 8'd1);
    goto(4);  check("a_fs_n4", fs_a, 1'b0);
              check("b_fs_n4", fs_b, 1'b0);
              check("b_addr_p3", vram_b.O_VRAM_ADDR, 8'd1);
    goto(5);  check("b_fs_n5", fs_b, 1'b1);
    goto(10); check("b_rgb_5_0", {r_b, g_b, b_b}, 12'h00F);
    goto(32); check("b_addr_p31", vram_b.O_VRAM_ADDR, 8'd15);
    goto(33); check("b_en_p32",   vram_b.O_VRAM_EN, 1'b0);
              check("b_addr_p32", vram_b.O_VRAM_ADDR, 8'd0);
    goto(45); check("b_border_40_0", {r_b, g_b, b_b}, 12'h3C7);

    // ---- hsync edges: B lands 2 cycles after C ----
    goto(70); check("c_hs_px67", hs_c, 1'b1);
    goto(71); check("c_hs_px68", hs_c, 1'b0);
    goto(72); check("b_hs_px67", hs_b, 1'b1);
    goto(73); check("b_hs_px68", hs_b, 1'b0);

    goto(84);  check("b_addr_3_1", vram_b.O_VRAM_ADDR, 8'd1);
    goto(161); check("b_addr_0_2", vram_b.O_VRAM_ADDR, 8'd16);
    goto(172); check("b_rgb_7_2",  {r_b, g_b, b_b}, 12'hF0F);

    goto(666); check("a_hs_px663", hs_a, 1'b1);
    goto(667); check("a_hs_px664", hs_a, 1'b0);
    goto(706); check("a_hs_px703", hs_a, 1'b0);
    goto(707); check("a_hs_px704", hs_a, 1'b1);

    // ---- mid-frame change of C's window/border: must wait for next frame ----
    goto(801);
    win_x_c = 10'd0;
    bord_c  = BORD_C_NEW;

    goto(834);
    cnt_hs = 0;
    for (int i = 0; i < 832; i++) begin
      step();
      if (!hs_a) cnt_hs++;
    end
    check("a_hs_low_line1", cnt_hs, 40);

    goto(2013); check("c_old_border_10_25", {r_c, g_c, b_c}, 12'h123);

    // ---- C window clipped at right/bottom edge ----
    goto(3257); check("c_addr_56_40", vram_c.O_VRAM_ADDR, 8'd0);
                check("c_en_56_40",   vram_c.O_VRAM_EN, 1'b1);
    goto(3263); check("c_rgb_60_40",  {r_c, g_c, b_c}, 12'h0F0);
    goto(3264); check("c_addr_63_40", vram_c.O_VRAM_ADDR, 8'd7);
    goto(3265); check("c_en_64_40",   vram_c.O_VRAM_EN, 1'b0);
                check("c_addr_64_40", vram_c.O_VRAM_ADDR, 8'd0);
    goto(3337); check("c_addr_56_41", vram_c.O_VRAM_ADDR, 8'd16);

    // ---- A window at (192,4) ----
    goto(3431); check("a_border_100_4", {r_a, g_a, b_a}, 12'hA5C);
    goto(3520); check("a_en_191_4",     vram_a.O_VRAM_EN, 1'b0);
    goto(3521); check("a_addr_192_4",   vram_a.O_VRAM_ADDR, 16'd0);
                check("a_en_192_4",     vram_a.O_VRAM_EN, 1'b1);
    goto(3528); check("a_rgb_197_4",    {r_a, g_a, b_a}, 12'hFF0);
    goto(3776); check("a_addr_447_4",   vram_a.O_VRAM_ADDR, 16'd255);
    goto(3777); check("a_en_448_4",     vram_a.O_VRAM_EN, 1'b0);

    goto(3824); check("c_addr_63_47", vram_c.O_VRAM_ADDR, 8'd119);
    goto(3842); check("c_vb_79_47",   vb_c, 1'b0);
    goto(3843); check("c_vb_0_48",    vb_c, 1'b1);
    goto(3923); check("c_vs_ln49",    vs_c, 1'b1);
    goto(4003); check("c_vs_ln50",    vs_c, 1'b0);
    goto(4162); check("c_vs_79_51",   vs_c, 1'b0);
    goto(4163); check("c_vs_ln52",    vs_c, 1'b1);
    goto(4353); check("a_addr_192_5", vram_a.O_VRAM_ADDR, 16'd256);

    // ---- C frame 1: new shadow values active ----
    goto(4482); check("c_fs_end_f0", fs_c, 1'b0);
    goto(4483); check("c_fs_f1",     fs_c, 1'b1);
    goto(6503); check("c_new_border_20_25", {r_c, g_c, b_c}, BORD_C_NEW);
    goto(7773); check("c_rgb_10_41_f1",     {r_c, g_c, b_c}, 12'h00F);

    // ---- C frame 2: whole-frame counts ----
    goto(8962);
    cnt_hs = 0; cnt_vs = 0; cnt_vb = 0; cnt_fs = 0;
    for (int i = 0; i < 4480; i++) begin
      step();
      if (!hs_c) cnt_hs++;
      if (!vs_c) cnt_vs++;
      if (vb_c)  cnt_vb++;
      if (fs_c)  cnt_fs++;
    end
    check("c_frame_hs_low", cnt_hs, 336);
    check("c_frame_vs_low", cnt_vs, 160);
    check("c_frame_vblank", cnt_vb, 640);
    check("c_frame_fs_cnt", cnt_fs, 1);
    goto(13443); check("c_fs_f3", fs_c, 1'b1);

    // ---- reset in the middle of frame 3 (line 30), window moved off-screen ----
    goto(15843);
    win_x_c = 10'd100;
    rst     = 1'b1;
    step();
    check("c_mrst_rgb",  {r_c, g_c, b_c}, 12'h000);
    check("c_mrst_en",   vram_c.O_VRAM_EN, 1'b0);
    check("c_mrst_addr", vram_c.O_VRAM_ADDR, 8'd0);
    check("c_mrst_hs",   hs_c, 1'b1);
    check("b_mrst_en",   vram_b.O_VRAM_EN, 1'b0);
    step();
    rst = 1'b0;
    n   = 0;
    goto(1); check("c_post_rst_rgb", {r_c, g_c, b_c}, 12'h000);
             check("c_post_rst_vb",  vb_c, 1'b0);
    goto(2); check("c_post_rst_fs_n2", fs_c, 1'b0);
    goto(3); check("c_post_rst_fs_n3", fs_c, 1'b1);
             check("c_post_rst_rgb00", {r_c, g_c, b_c}, BORD_C_NEW);
    cnt_en = 0;
    for (int i = 0; i < 4480; i++) begin
      step();
      if (vram_c.O_VRAM_EN) cnt_en++;
    end
    check("c_offscreen_no_reads", cnt_en, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_window_scaler.md
Name: vga_window_scaler

Overview:
- Parametrised VGA timing generator with a windowed, integer-scaled framebuffer fetch.
- Generates HSYNC/VSYNC for a configurable mode, issues VRAM read addresses for a window that can be moved at run time, and compensates for VRAM read latency.
- Outputs registered RGB, aligned to sync.
- Sits between the video RAM read port and the board VGA DAC pins; replaces the fixed 640x480 / 256x256 generator.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 128, horizontal back porch; H_TOTAL = sum = 832
- V_ACTIVE, 480, visible lines
- V_FP, 9, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 29, vertical back porch; V_TOTAL = sum = 520
- SYNC_POL, 0, asserted level of HSYNC/VSYNC (0 = active-low)
- WIN_W, 256, window width in source pixels
- WIN_H, 256, window height in source pixels
- SCALE_SHIFT, 0, on-screen magnification = 1<<SCALE_SHIFT in both axes
- ADDR_W, 16, VRAM address width; must be >= log2(WIN_W*WIN_H)
- RAM_LAT, 1, VRAM read latency in cycles, from address valid to data valid (>=1)

Ports:
- CLK  in  1  pixel clock
- I_RESET  in  1  synchronous reset, active-high
- I_WIN_X  in  10  window left edge, screen pixels
- I_WIN_Y  in  10  window top edge, screen lines
- I_BORDER  in  12  border colour {R,G,B}, 4b each
- O_VRAM_ADDR  out  ADDR_W  registered read address
- O_VRAM_EN  out  1  read enable; high when the address targets the window
- I_VRAM_DATA  in  3  pixel data; bit0=R, bit1=B, bit2=G
- O_HSYNC  out  1  horizontal sync
- O_VSYNC  out  1  vertical sync
- O_VIDEO_R  out  4  red
- O_VIDEO_G  out  4  green
- O_VIDEO_B  out  4  blue
- O_FRAME_START  out  1  one-cycle pulse aligned with output of pixel (0,0)
- O_VBLANK  out  1  high while output line >= V_ACTIVE

Behaviour:
- Counters:
  - px counts 0..H_TOTAL-1 and wraps to 0.
  - ln increments when px wraps, counts 0..V_TOTAL-1 and wraps to 0.
  - Both are 0 after reset; the first post-reset cycle processes px=0, ln=0.
- Stage 0 (combinational on counters):
  - active = px<H_ACTIVE && ln<V_ACTIVE.
  - hs = px in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vs = ln in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - in_win = active && px-wx in [0, WIN_W<<SCALE_SHIFT) && ln-wy in [0, WIN_H<<SCALE_SHIFT), computed with 11-bit signed differences. Window pixels outside the active area are clipped (blank).
- Shadow registers wx, wy, border:
  - Loaded from I_WIN_X/I_WIN_Y/I_BORDER during reset and on the cycle px=H_TOTAL-1 && ln=V_TOTAL-1.
  - Input changes mid-frame have no effect until the next frame.
- Stage 1 (registered):
  - O_VRAM_ADDR = ((ln-wy)>>SCALE_SHIFT)*WIN_W + ((px-wx)>>SCALE_SHIFT), truncated to ADDR_W, when in_win; 0 otherwise.
  - O_VRAM_EN = in_win.
- Flag pipeline:
  - Flags {active, in_win, hs, vs, frame0 = (px==0&&ln==0), vblank = ln>=V_ACTIVE} are delayed RAM_LAT+1 cycles by a shift register.
  - At output they are registered together with the data select.
- Output stage (registered):
  - Total latency from counter value to O_* pins = RAM_LAT+2 cycles, identical for sync, RGB and flags.
  - in_win: each channel = its data bit replicated to 4 bits.
  - active && !in_win: border colour.
  - !active: 0.
  - O_HSYNC = hs ? SYNC_POL : !SYNC_POL; O_VSYNC likewise.
- Reset values:
  - Counters 0, pipeline flushed (all flags 0), O_VRAM_ADDR 0, O_VRAM_EN 0.
  - RGB 0, O_FRAME_START 0, O_VBLANK 0.
  - O_HSYNC = O_VSYNC = !SYNC_POL.
- Reset mid-frame:
  - Takes effect on the next edge; all in-flight pipeline contents are discarded.
  - Output resumes with pixel (0,0) RAM_LAT+2 cycles after I_RESET deasserts.
- Boundaries:
  - Window touching px=H_ACTIVE-1 or ln=V_ACTIVE-1 is clipped without address wrap.
  - A window starting beyond the active area produces no reads.
  - WIN_W is a power of two in the default build; otherwise a multiply is inferred.

Test Plan:
- Reset held 5 cycles, then released: during reset RGB=0, HSYNC=VSYNC=1, VRAM_EN=0; O_FRAME_START pulses exactly RAM_LAT+2 cycles after release, then every 832*520 cycles.
- Default mode, one frame observed: HSYNC low for 40 cycles/line (counter 664..703, shifted by latency); VSYNC low on lines 489..490 only; O_VBLANK high for 40 lines.
- WIN_X=192, WIN_Y=112, SCALE_SHIFT=0:
  - Address at (192,112) = 0; (447,112) = 255; (192,113) = 256; (447,367) = 65535.
  - VRAM_EN low at (191,112) and (448,112).
  - Pixels outside the window inside the active area show I_BORDER.
- SCALE_SHIFT=1, WIN_X=0, WIN_Y=0:
  - Address sequence on line 0 is 0,0,1,1,...,255,255.
  - Line 1 repeats line 0; line 2 starts at 256.
  - Pixels 512..639 show border.
- RAM_LAT=3 with a behavioural RAM model of latency 3 returning addr[2:0]: RGB at each output pixel matches that pixel's address, and sync edges land at the same cycle offsets as in the RAM_LAT=1 build plus 2.
- I_BORDER and I_WIN_X changed at line 100: the current frame is unchanged; the new values apply from the next O_FRAME_START. I_RESET asserted at line 300 restarts the frame per the reset rules.
